// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data memory, with WAIT_CYCLES extra access cycles per transfer.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              winner;
  logic              we_own;
  logic [ADDR_W-1:0] adr_own;
  logic [DATA_W-1:0] wdata_own;
  logic              last_access;

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic rr_ptr;

  // rr_ptr names the port that wins the next tie.
  assign winner = (req0 & req1) ? rr_ptr : req1;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (state == IDLE && any_req)
      rr_ptr <= ~winner;
  end
`endif

  assign we_own      = owner ? we1    : we0;
  assign adr_own     = owner ? adr1   : adr0;
  assign wdata_own   = owner ? wdata1 : wdata0;
  assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      wait_cnt <= 4'd0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            wait_cnt <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
          else if (!we_own)
            rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // The memory side is only driven during ACCESS; the write strobe fires once, in the final cycle.
  always_comb begin
    mem_adr   = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      mem_adr   = adr_own;
      mem_wdata = wdata_own;
      mem_read  = ~we_own;
      mem_write = last_access & we_own & ~rst;
    end
    if (state == RESP && !rst) begin
      if (owner) begin
        ack1   = 1'b1;
        rdata1 = rdata_q;
      end else begin
        ack0   = 1'b1;
        rdata0 = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: three instances (WAIT_CYCLES 1, 0, 15) checked cycle by cycle
// against a transaction-level schedule model with its own reference memory.
module tb_dmem_arbiter;

  localparam int N    = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst       [N];
  logic        req0      [N];
  logic        we0       [N];
  logic [31:0] adr0      [N];
  logic [31:0] wdata0    [N];
  logic        ack0      [N];
  logic [31:0] rdata0    [N];
  logic        req1      [N];
  logic        we1       [N];
  logic [31:0] adr1      [N];
  logic [31:0] wdata1    [N];
  logic        ack1      [N];
  logic [31:0] rdata1    [N];
  logic [31:0] mem_adr   [N];
  logic [31:0] mem_wdata [N];
  logic        mem_read  [N];
  logic        mem_write [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];
  logic        owner     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 15)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .req0(req0[g]), .we0(we0[g]), .adr0(adr0[g]), .wdata0(wdata0[g]), .ack0(ack0[g]), .rdata0(rdata0[g]),
      .req1(req1[g]), .we1(we1[g]), .adr1(adr1[g]), .wdata1(wdata1[g]), .ack1(ack1[g]), .rdata1(rdata1[g]),
      .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g])
    );
  end

  function automatic int wc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 15;
  endfunction

  function automatic logic [31:0] pat(input int k, input int j);
    return 32'hA500_0000 | 32'(k << 8) | 32'(j);
  endfunction

  // Memory attached to each instance: clocked write, combinational read.
  logic [31:0] tbmem [N][32];
  logic        mem_init;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_init)
        for (int j = 0; j < 32; j++) tbmem[k][j] <= pat(k, j);
      else if (mem_write[k])
        tbmem[k][mem_adr[k][4:0]] <= mem_wdata[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) mem_rdata[k] = tbmem[k][mem_adr[k][4:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: one scheduled transaction per instance, timed by cycle offsets.
  bit          active   [N];
  int          gcyc     [N];
  bit          gwin     [N];
  bit          gwe      [N];
  logic [31:0] gadr     [N];
  logic [31:0] gwd      [N];
  bit          rr       [N];
  bit          mowner   [N];
  logic [31:0] last_rd  [N];
  logic [31:0] ref_mem  [N][32];
  bit          rst_done [N];
  int          nres     [N];

  bit          seen_ack [N][2];
  int          done     [N][2];
  bit          lat_done [N];

  bit          e_busy  [N];
  bit          e_mr    [N];
  bit          e_mw    [N];
  bit          e_ack0  [N];
  bit          e_ack1  [N];
  logic [31:0] e_adr   [N];
  logic [31:0] e_wd    [N];
  logic [31:0] e_rd0   [N];
  logic [31:0] e_rd1   [N];

  task automatic load(input int i, input int p, input bit r, input bit we, input logic [31:0] a,
                      input logic [31:0] d);
    if (p == 0) begin
      req0[i] = r; we0[i] = we; adr0[i] = a; wdata0[i] = d;
    end else begin
      req1[i] = r; we1[i] = we; adr1[i] = a; wdata1[i] = d;
    end
  endtask

  task automatic rand_txn(input int i, input int p);
    load(i, p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic drive(input int i, input int c);
    bit cur;
    if (rst_done[i]) begin
      rst[i]  = 1'b0;
      req0[i] = 1'b0;
      req1[i] = 1'b0;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      cur = (p == 0) ? req0[i] : req1[i];
      if (cur && seen_ack[i][p]) begin
        if (c >= 60 && c < 400)                         rand_txn(i, p);
        else if (c >= 400 && $urandom_range(0, 1) == 1) rand_txn(i, p);
        else if (p == 0)                                req0[i] = 1'b0;
        else                                            req1[i] = 1'b0;
      end else if (!cur) begin
        if (c < 60) begin
          if (p == 0 && c == 2)
            load(i, 0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
          else if (p == 1 && done[i][0] >= 1 && done[i][1] == 0)
            load(i, 1, 1'b1, 1'b0, 32'h10, $urandom);
        end else if (c < 400) begin
          rand_txn(i, p);
        end else if ($urandom_range(0, 2) == 0) begin
          rand_txn(i, p);
        end
      end
    end
  endtask

  task automatic model(input int i, input int c);
    int  d;
    bit  win;
    if (rst_done[i]) begin
      rst_done[i] = 1'b0;
      active[i]   = 1'b0;
      rr[i]       = 1'b0;
      mowner[i]   = 1'b0;
      last_rd[i]  = '0;
    end
    e_busy[i] = 0; e_mr[i] = 0; e_mw[i] = 0; e_ack0[i] = 0; e_ack1[i] = 0;
    e_adr[i] = '0; e_wd[i] = '0; e_rd0[i] = '0; e_rd1[i] = '0;
    if (active[i] && (c - gcyc[i]) == wc(i) + 3) active[i] = 1'b0;
    if (active[i]) begin
      d = c - gcyc[i];
      e_busy[i] = 1'b1;
      if (d == 1) mowner[i] = gwin[i];
      if (d <= wc(i) + 1) begin
        e_mr[i]  = ~gwe[i];
        e_adr[i] = gadr[i];
        e_wd[i]  = gwd[i];
        if (d == wc(i) + 1) begin
          if (gwe[i] && c > 1000 && nres[i] < 3 && $urandom_range(0, 3) == 0) begin
            rst[i]      = 1'b1;
            rst_done[i] = 1'b1;
            nres[i]++;
          end
          e_mw[i] = gwe[i] & ~rst[i];
          if (!rst[i]) begin
            if (gwe[i]) ref_mem[i][gadr[i][4:0]] = gwd[i];
            else        last_rd[i] = ref_mem[i][gadr[i][4:0]];
          end
        end
      end else if (gwin[i]) begin
        e_ack1[i] = 1'b1;
        e_rd1[i]  = last_rd[i];
      end else begin
        e_ack0[i] = 1'b1;
        e_rd0[i]  = last_rd[i];
      end
    end else if (req0[i] || req1[i]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win = ~req0[i];
`else
      win = (req0[i] && req1[i]) ? rr[i] : req1[i];
`endif
      active[i] = 1'b1;
      gcyc[i]   = c;
      gwin[i]   = win;
      gwe[i]    = win ? we1[i]    : we0[i];
      gadr[i]   = win ? adr1[i]   : adr0[i];
      gwd[i]    = win ? wdata1[i] : wdata0[i];
      rr[i]     = ~win;
    end
  endtask

  task automatic compare(input int i, input int c);
    string pfx;
    pfx = $sformatf("u%0d c%0d", i, c);
    check({pfx, " busy"},      busy[i],      e_busy[i]);
    check({pfx, " owner"},     owner[i],     mowner[i]);
    check({pfx, " ack0"},      ack0[i],      e_ack0[i]);
    check({pfx, " ack1"},      ack1[i],      e_ack1[i]);
    check({pfx, " rdata0"},    rdata0[i],    e_rd0[i]);
    check({pfx, " rdata1"},    rdata1[i],    e_rd1[i]);
    check({pfx, " mem_read"},  mem_read[i],  e_mr[i]);
    check({pfx, " mem_write"}, mem_write[i], e_mw[i]);
    check({pfx, " mem_adr"},   mem_adr[i],   e_adr[i]);
    check({pfx, " mem_wdata"}, mem_wdata[i], e_wd[i]);
    if (c < 60 && ack0[i] && !lat_done[i]) begin
      lat_done[i] = 1'b1;
      check({pfx, " first_write_latency"}, 64'(c - 2), 64'(wc(i) + 2));
    end
    if (c < 60 && ack1[i])
      check({pfx, " directed_read_data"}, rdata1[i], 32'hDEAD_BEEF);
    seen_ack[i][0] = e_ack0[i];
    seen_ack[i][1] = e_ack1[i];
    if (e_ack0[i]) done[i][0]++;
    if (e_ack1[i]) done[i][1]++;
  endtask

  initial begin
    mem_init = 1'b1;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      load(i, 0, 1'b0, 1'b0, '0, '0);
      load(i, 1, 1'b0, 1'b0, '0, '0);
      active[i] = 0; rr[i] = 0; mowner[i] = 0; last_rd[i] = '0; rst_done[i] = 0; nres[i] = 0;
      seen_ack[i][0] = 0; seen_ack[i][1] = 0; done[i][0] = 0; done[i][1] = 0; lat_done[i] = 0;
      for (int j = 0; j < 32; j++) ref_mem[i][j] = pat(i, j);
    end
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d reset busy", i),   busy[i],   1'b0);
      check($sformatf("u%0d reset owner", i),  owner[i],  1'b0);
      check($sformatf("u%0d reset ack0", i),   ack0[i],   1'b0);
      check($sformatf("u%0d reset ack1", i),   ack1[i],   1'b0);
      check($sformatf("u%0d reset rdata0", i), rdata0[i], 32'h0);
      check($sformatf("u%0d reset rdata1", i), rdata1[i], 32'h0);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        drive(i, c);
        model(i, c);
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) compare(i, c);
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d directed txns done", i), 64'(done[i][0] > 0 && done[i][1] > 0), 64'd1);
      check($sformatf("u%0d mid-write resets", i), 64'(nres[i] > 0), 64'd1);
      for (int j = 0; j < 32; j++)
        check($sformatf("u%0d mem[%0d]", i, j), tbmem[i][j], ref_mem[i][j]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
